// File: rtl/vram_arbiter_pkg.sv
// Shared definitions for the VRAM arbiter: text-RAM geometry, timing
// constants and the CPU access state encoding.
package vram_arbiter_pkg;

    localparam int unsigned ADDR_W   = 9;   // {row[3:0], col[4:0]}
    localparam int unsigned DATA_W   = 8;
    localparam int unsigned LAST_COL = 41;  // final (short) column of a line
    localparam int unsigned VIS_COLS = 32;
    localparam int unsigned VIS_ROWS = 16;

    typedef enum logic [1:0] {
        CPU_IDLE = 2'd0,
        CPU_DATA = 2'd1,
        CPU_DONE = 2'd2
    } cpu_state_t;

endpackage

// File: rtl/vram_cursor_blink.sv
// Cursor blink generator: counts rising edges of vsync in a 5-bit frame
// counter; the cursor is shown during the upper half of each 32-frame cycle.
// Ports:
//   clk    - pixel clock
//   rst_n  - asynchronous active-low reset
//   vsync  - vertical sync, active-high
//   blink  - 1 while the cursor should be visible (frame counter bit 4)
module vram_cursor_blink (
    input  logic clk,
    input  logic rst_n,
    input  logic vsync,
    output logic blink
);

    logic       vsync_prev;
    logic [4:0] frame_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vsync_prev <= 1'b0;
            frame_cnt  <= '0;
        end else begin
            vsync_prev <= vsync;
            if (vsync && !vsync_prev)
                frame_cnt <= frame_cnt + 5'd1;   // wraps 31 -> 0 naturally
        end
    end

    assign blink = frame_cnt[4];

endmodule

// File: rtl/vram_arbiter.sv
// Arbitrates the single-port text RAM between the display prefetch and a
// CPU. In one fixed pixel phase per column the display reads the next
// column's character; the CPU gets the port in every other cycle.
// Ports:
//   clk, rst_n            - pixel clock, asynchronous active-low reset
//   x_hi, x_lo, y_hi      - beam position (column, pixel-in-column, row)
//   vsync                 - vertical sync (drives cursor blink)
//   cpu_req/we/addr/wdata - CPU access request, held until cpu_ready
//   cpu_ready, cpu_rdata  - completion pulse and read data
//   mem_addr/we/wdata     - text RAM port; mem_rdata returns 1 cycle later
//   cursor_addr/en        - cursor cell and enable
//   char_code/char_cursor - character and cursor flag for the current column
module vram_arbiter
    import vram_arbiter_pkg::*;
#(
    parameter int unsigned FETCH_SLOT = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [5:0]        x_hi,
    input  logic [4:0]        x_lo,
    input  logic [4:0]        y_hi,
    input  logic              vsync,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ready,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic [ADDR_W-1:0] cursor_addr,
    input  logic              cursor_en,
    output logic [DATA_W-1:0] char_code,
    output logic              char_cursor
);

    localparam logic [5:0] LAST_COL_X   = 6'(LAST_COL);
    localparam logic [5:0] LAST_FETCH_X = 6'(VIS_COLS - 2);
    localparam logic [4:0] ROWS_Y       = 5'(VIS_ROWS);
    localparam logic [4:0] SLOT_X       = 5'(FETCH_SLOT);

    cpu_state_t        state, state_next;
    logic              blink;
    logic              have_target;
    logic [4:0]        target_col;
    logic [ADDR_W-1:0] fetch_addr;
    logic              disp_slot;
    logic              boundary;
    logic              fetch_pending;
    logic [ADDR_W-1:0] fetch_addr_q;
    logic [DATA_W-1:0] next_char;
    logic              next_cur;
    logic              next_valid;

    vram_cursor_blink u_blink (
        .clk   (clk),
        .rst_n (rst_n),
        .vsync (vsync),
        .blink (blink)
    );

    // The display fetches one column ahead; the last (short) column of a
    // line prefetches column 0 of the same row.
    always_comb begin
        have_target = 1'b0;
        target_col  = '0;
        if (y_hi < ROWS_Y) begin
            if (x_hi <= LAST_FETCH_X) begin
                have_target = 1'b1;
                target_col  = 5'(x_hi + 6'd1);
            end else if (x_hi == LAST_COL_X) begin
                have_target = 1'b1;
            end
        end
    end

    assign fetch_addr = {y_hi[3:0], target_col};
    assign disp_slot  = have_target && (x_lo == SLOT_X);
    assign boundary   = (x_lo == 5'd31) || ((x_hi == LAST_COL_X) && (x_lo == 5'd15));

    // Display pipeline: capture read data one cycle after the fetch slot,
    // present it at the next column boundary.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pending <= 1'b0;
            fetch_addr_q  <= '0;
            next_char     <= '0;
            next_cur      <= 1'b0;
            next_valid    <= 1'b0;
            char_code     <= '0;
            char_cursor   <= 1'b0;
        end else begin
            fetch_pending <= disp_slot;
            if (disp_slot)
                fetch_addr_q <= fetch_addr;
            if (fetch_pending) begin
                next_char  <= mem_rdata;
                next_cur   <= cursor_en && blink && (fetch_addr_q == cursor_addr);
                next_valid <= 1'b1;
            end
            if (boundary) begin
                char_code   <= next_valid ? next_char : '0;
                char_cursor <= next_valid && next_cur;
                next_valid  <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= CPU_IDLE;
        else
            state <= state_next;
    end

    // Port mux and CPU next state; the display slot always owns the port.
    always_comb begin
        state_next = state;
        mem_addr   = '0;
        mem_we     = 1'b0;
        mem_wdata  = '0;
        if (disp_slot)
            mem_addr = fetch_addr;
        case (state)
            CPU_IDLE: begin
                if (cpu_req && !disp_slot) begin
                    mem_addr   = cpu_addr;
                    mem_we     = cpu_we;
                    mem_wdata  = cpu_wdata;
                    state_next = CPU_DATA;
                end
            end
            CPU_DATA: state_next = CPU_DONE;
            CPU_DONE: begin
                if (!cpu_req)
                    state_next = CPU_IDLE;
            end
            default: state_next = CPU_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cpu_ready <= 1'b0;
            cpu_rdata <= '0;
        end else begin
            cpu_ready <= (state == CPU_DATA);
            if ((state == CPU_DATA) && !cpu_we)
                cpu_rdata <= mem_rdata;
        end
    end

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed bench for vram_arbiter: a table of port-mux vectors followed by
// hand-written sequences for CPU timing, display prefetch, cursor blink
// and mid-transaction reset. A behavioural text RAM sits on the mem port.
module tb_vram_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] x_hi;
    logic [4:0] x_lo;
    logic [4:0] y_hi;
    logic       vsync;
    logic       cpu_req;
    logic       cpu_we;
    logic [8:0] cpu_addr;
    logic [7:0] cpu_wdata;
    logic       cpu_ready;
    logic [7:0] cpu_rdata;
    logic [8:0] mem_addr;
    logic       mem_we;
    logic [7:0] mem_wdata;
    logic [7:0] mem_rdata;
    logic [8:0] cursor_addr;
    logic       cursor_en;
    logic [7:0] char_code;
    logic       char_cursor;

    int checks = 0;
    int errors = 0;

    vram_arbiter #(.FETCH_SLOT(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .x_hi        (x_hi),
        .x_lo        (x_lo),
        .y_hi        (y_hi),
        .vsync       (vsync),
        .cpu_req     (cpu_req),
        .cpu_we      (cpu_we),
        .cpu_addr    (cpu_addr),
        .cpu_wdata   (cpu_wdata),
        .cpu_ready   (cpu_ready),
        .cpu_rdata   (cpu_rdata),
        .mem_addr    (mem_addr),
        .mem_we      (mem_we),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata),
        .cursor_addr (cursor_addr),
        .cursor_en   (cursor_en),
        .char_code   (char_code),
        .char_cursor (char_cursor)
    );

    always #5 clk = ~clk;

    // Synchronous single-port RAM, one-cycle read latency.
    logic [7:0] ram [512];
    always @(posedge clk) begin
        if (mem_we)
            ram[mem_addr] <= mem_wdata;
        mem_rdata <= ram[mem_addr];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue one CPU access; lat = cycles from request to cpu_ready (-1 on timeout).
    task automatic cpu_access(input logic we, input logic [8:0] addr, input logic [7:0] wd,
                              output int lat, output logic [7:0] rd);
        cpu_we    = we;
        cpu_addr  = addr;
        cpu_wdata = wd;
        cpu_req   = 1'b1;
        lat       = -1;
        for (int k = 0; k < 10; k++) begin
            if (cpu_ready) begin
                lat = k;
                break;
            end
            step();
        end
        rd      = cpu_rdata;
        cpu_req = 1'b0;
        step();
    endtask

    // Scan one full column of row y, leaving the beam at pixel 0 of the next column.
    task automatic run_col(input logic [4:0] y, input logic [5:0] xh);
        int unsigned last;
        last = (xh == 6'd41) ? 15 : 31;
        y_hi = y;
        x_hi = xh;
        for (int unsigned lo = 0; lo <= last; lo++) begin
            x_lo = 5'(lo);
            step();
        end
        x_hi = (xh == 6'd41) ? 6'd0 : xh + 6'd1;
        x_lo = 5'd0;
        #1;
    endtask

    task automatic vsync_pulses(input int n);
        for (int i = 0; i < n; i++) begin
            vsync = 1'b1;
            step();
            vsync = 1'b0;
            step();
        end
    endtask

    typedef struct {
        logic [5:0] xh;
        logic [4:0] xl;
        logic [4:0] y;
        logic       req;
        logic       we;
        logic [8:0] addr;
        logic [7:0] wd;
        logic [8:0] e_addr;
        logic       e_we;
        logic [7:0] e_wd;
    } vec_t;

    vec_t vecs [11];

    initial begin
        int         lat;
        logic [7:0] rd;
        int         pulses;

        vecs[0]  = '{6'd4,  5'd4, 5'd1,  1'b0, 1'b0, 9'h000, 8'h00, 9'h025, 1'b0, 8'h00};
        vecs[1]  = '{6'd4,  5'd4, 5'd1,  1'b1, 1'b1, 9'h1FF, 8'hAA, 9'h025, 1'b0, 8'h00};
        vecs[2]  = '{6'd4,  5'd3, 5'd1,  1'b1, 1'b1, 9'h1FF, 8'hAA, 9'h1FF, 1'b1, 8'hAA};
        vecs[3]  = '{6'd41, 5'd4, 5'd2,  1'b0, 1'b0, 9'h000, 8'h00, 9'h040, 1'b0, 8'h00};
        vecs[4]  = '{6'd30, 5'd4, 5'd15, 1'b0, 1'b0, 9'h000, 8'h00, 9'h1FF, 1'b0, 8'h00};
        vecs[5]  = '{6'd31, 5'd4, 5'd0,  1'b0, 1'b0, 9'h000, 8'h00, 9'h000, 1'b0, 8'h00};
        vecs[6]  = '{6'd40, 5'd4, 5'd0,  1'b0, 1'b0, 9'h000, 8'h00, 9'h000, 1'b0, 8'h00};
        vecs[7]  = '{6'd0,  5'd4, 5'd16, 1'b0, 1'b0, 9'h000, 8'h00, 9'h000, 1'b0, 8'h00};
        vecs[8]  = '{6'd0,  5'd4, 5'd16, 1'b1, 1'b0, 9'h123, 8'h00, 9'h123, 1'b0, 8'h00};
        vecs[9]  = '{6'd0,  5'd4, 5'd0,  1'b0, 1'b0, 9'h000, 8'h00, 9'h001, 1'b0, 8'h00};
        vecs[10] = '{6'd0,  5'd5, 5'd0,  1'b0, 1'b0, 9'h000, 8'h00, 9'h000, 1'b0, 8'h00};

        rst_n = 1'b0; x_hi = '0; x_lo = '0; y_hi = '0; vsync = 1'b0;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        cursor_addr = '0; cursor_en = 1'b0;
        #12;
        chk("rst_cpu_ready", cpu_ready, 0);
        chk("rst_cpu_rdata", cpu_rdata, 0);
        chk("rst_char_code", char_code, 0);
        chk("rst_char_cursor", char_cursor, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_we", mem_we, 0);
        step();
        rst_n = 1'b1;
        step();

        // Port mux vectors: applied and cleared between clock edges so the FSM stays idle.
        for (int i = 0; i < 11; i++) begin
            x_hi = vecs[i].xh; x_lo = vecs[i].xl; y_hi = vecs[i].y;
            cpu_req = vecs[i].req; cpu_we = vecs[i].we;
            cpu_addr = vecs[i].addr; cpu_wdata = vecs[i].wd;
            #1;
            chk($sformatf("vec%0d_addr", i), mem_addr, vecs[i].e_addr);
            chk($sformatf("vec%0d_we", i), mem_we, vecs[i].e_we);
            chk($sformatf("vec%0d_wdata", i), mem_wdata, vecs[i].e_wd);
            cpu_req = 1'b0;
            step();
        end

        // CPU write without collision.
        x_hi = 6'd10; x_lo = 5'd10; y_hi = 5'd20;
        cpu_we = 1'b1; cpu_addr = 9'h025; cpu_wdata = 8'h41; cpu_req = 1'b1;
        #1;
        chk("wr_mem_addr", mem_addr, 9'h025);
        chk("wr_mem_we", mem_we, 1);
        chk("wr_mem_wdata", mem_wdata, 8'h41);
        step();
        chk("wr_we_one_cycle", mem_we, 0);
        chk("wr_ready_n1", cpu_ready, 0);
        step();
        chk("wr_ready_n2", cpu_ready, 1);
        cpu_req = 1'b0;
        step();
        chk("wr_ready_pulse", cpu_ready, 0);
        chk("wr_ram", ram[9'h025], 8'h41);
        step();

        // Preload cells used later.
        cpu_access(1'b1, 9'h040, 8'h58, lat, rd); chk("pre40_lat", lat, 2);
        cpu_access(1'b1, 9'h041, 8'h33, lat, rd); chk("pre41_lat", lat, 2);
        cpu_access(1'b1, 9'h05F, 8'h7E, lat, rd); chk("pre5f_lat", lat, 2);
        cpu_access(1'b1, 9'h1FF, 8'hC3, lat, rd); chk("pre1ff_lat", lat, 2);
        cpu_access(1'b0, 9'h041, 8'h00, lat, rd);
        chk("rd41_lat", lat, 2);
        chk("rd41_data", rd, 8'h33);

        // CPU read colliding with the display slot at x_hi 4, y_hi 1.
        x_hi = 6'd4; x_lo = 5'd4; y_hi = 5'd1;
        cpu_we = 1'b0; cpu_addr = 9'h1FF; cpu_req = 1'b1;
        #1;
        chk("col_disp_addr", mem_addr, 9'h025);
        chk("col_disp_we", mem_we, 0);
        step();
        x_lo = 5'd5;
        #1;
        chk("col_cpu_addr", mem_addr, 9'h1FF);
        chk("col_ready_n1", cpu_ready, 0);
        step();
        x_lo = 5'd6;
        chk("col_ready_n2", cpu_ready, 0);
        step();
        x_lo = 5'd7;
        chk("col_ready_n3", cpu_ready, 1);
        chk("col_rdata", cpu_rdata, 8'hC3);
        cpu_req = 1'b0;
        step();
        chk("col_ready_pulse", cpu_ready, 0);

        // End-of-line: column 31 fetched, columns 32..40 blank and silent, 41 prefetches col 0.
        run_col(5'd2, 6'd30);
        chk("col31_char", char_code, 8'h7E);
        y_hi = 5'd2;
        for (int xh = 31; xh <= 40; xh++) begin
            for (int lo = 0; lo < 32; lo++) begin
                x_hi = 6'(xh); x_lo = 5'(lo);
                #1;
                if (lo == 4) begin
                    chk($sformatf("nofetch%0d_addr", xh), mem_addr, 0);
                    chk($sformatf("nofetch%0d_we", xh), mem_we, 0);
                end
                if (xh == 32 && lo == 0)
                    chk("col32_blank", char_code, 0);
                step();
            end
        end
        run_col(5'd2, 6'd41);
        chk("wrap_col0_char", char_code, 8'h58);
        chk("wrap_col0_cursor", char_cursor, 0);
        run_col(5'd2, 6'd0);
        chk("col1_char", char_code, 8'h33);

        // Cursor at row 9 col 3 with blink over the 32-frame cycle.
        cursor_addr = 9'h123; cursor_en = 1'b1;
        run_col(5'd9, 6'd2);
        chk("cur_frame0", char_cursor, 0);
        vsync_pulses(16);
        run_col(5'd9, 6'd2);
        chk("cur_frame16", char_cursor, 1);
        run_col(5'd9, 6'd3);
        chk("cur_next_col", char_cursor, 0);
        run_col(5'd8, 6'd2);
        chk("cur_other_row", char_cursor, 0);
        vsync_pulses(15);
        run_col(5'd9, 6'd2);
        chk("cur_frame31", char_cursor, 1);
        vsync_pulses(1);
        run_col(5'd9, 6'd2);
        chk("cur_frame_wrap", char_cursor, 0);
        cursor_en = 1'b0;

        // Reset while the FSM is in DATA.
        x_hi = 6'd10; x_lo = 5'd10; y_hi = 5'd20;
        chk("rdata_held", cpu_rdata, 8'hC3);
        cpu_we = 1'b0; cpu_addr = 9'h040; cpu_req = 1'b1;
        step();
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_ready", cpu_ready, 0);
        chk("midrst_rdata", cpu_rdata, 0);
        chk("midrst_char", char_code, 0);
        cpu_req = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        pulses = 0;
        for (int i = 0; i < 4; i++) begin
            if (cpu_ready) pulses++;
            step();
        end
        chk("midrst_no_pulse", pulses, 0);
        cpu_access(1'b0, 9'h040, 8'h00, lat, rd);
        chk("post_rst_lat", lat, 2);
        chk("post_rst_data", rd, 8'h58);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
